// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// Optional CMP support is selected with the ARM_CTRL_CMP_EN macro.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch
    } state_e;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluOrr = 2'b11;

    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdOrr = 4'b1100;
    localparam logic [3:0] CmdCmp = 4'b1010;

    localparam logic [1:0] SrcBRd2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondMi = 4'b0100;
    localparam logic [3:0] CondPl = 4'b0101;
    localparam logic [3:0] CondAl = 4'b1110;

    typedef struct packed {
        logic       supported;
        logic       is_cmp;
        logic [1:0] alu;
    } cmd_dec_t;

    function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
        cmd_dec_t d;
        d.supported = 1'b0;
        d.is_cmp    = 1'b0;
        d.alu       = AluAdd;
        case (cmd)
            CmdAdd: begin d.supported = 1'b1; d.alu = AluAdd; end
            CmdSub: begin d.supported = 1'b1; d.alu = AluSub; end
            CmdAnd: begin d.supported = 1'b1; d.alu = AluAnd; end
            CmdOrr: begin d.supported = 1'b1; d.alu = AluOrr; end
            CmdCmp: begin
`ifdef ARM_CTRL_CMP_EN
                d.supported = 1'b1;
                d.is_cmp    = 1'b1;
                d.alu       = AluSub;
`endif
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arm_cond_check.sv
// Stored {N,Z} flags and condition-code evaluation.
module arm_cond_check
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic       flag_we,
    input  logic       aluNeg,
    input  logic       aluZero,
    output logic       condex
);

    logic flag_n_q, flag_z_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else if (flag_we) begin
            flag_n_q <= aluNeg;
            flag_z_q <= aluZero;
        end
    end

    always_comb begin
        condex = 1'b0;
        case (cond)
            CondEq:  condex = flag_z_q;
            CondNe:  condex = !flag_z_q;
            CondMi:  condex = flag_n_q;
            CondPl:  condex = !flag_n_q;
            CondAl:  condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM with conditional execution.
// Define ARM_CTRL_CMP_EN to support CMP (flag-only compare, skips ALUWB).
module arm_mc_controller
    import arm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] Instr,
    input  logic        aluZero,
    input  logic        aluNeg,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  aluCtrl
);

    state_e   state_q, state_d;
    logic     condex, flag_we, in_exec;
    cmd_dec_t dec;

    wire [3:0] cond     = Instr[11:8];
    wire [1:0] op       = Instr[7:6];
    wire       imm_flag = Instr[5];
    wire       lsb      = Instr[0];   // S for data-processing, L for memory

    assign dec     = decode_cmd(Instr[4:1]);
    assign in_exec = (state_q == StExecR) || (state_q == StExecI);
    assign flag_we = in_exec && condex && dec.supported && (lsb || dec.is_cmp);

    arm_cond_check u_cond_check (
        .clk     (clk),
        .rst_n   (rst_n),
        .cond    (cond),
        .flag_we (flag_we),
        .aluNeg  (aluNeg),
        .aluZero (aluZero),
        .condex  (condex)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StFetch;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = imm_flag ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr:         state_d = lsb ? StMemRead : StMemWrite;
            StMemRead:        state_d = StMemWb;
            StExecR, StExecI: state_d = dec.is_cmp ? StFetch : StAluWb;
            default:          state_d = StFetch;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SrcBRd2;
        ResultSrc = ResAluOut;
        aluCtrl   = AluAdd;
        ImmSrc    = op;
        RegSrc    = {op == 2'b01, op == 2'b10};
        case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
                PCWrite   = 1'b1;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
            end
            StMemAdr:   ALUSrcB = SrcBImm;
            StMemRead:  AdrSrc  = 1'b1;
            StMemWb: begin
                ResultSrc = ResData;
                RegWrite  = condex;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = condex;
            end
            StExecR:    aluCtrl = dec.alu;
            StExecI: begin
                ALUSrcB = SrcBImm;
                aluCtrl = dec.alu;
            end
            StAluWb:    RegWrite = condex && dec.supported;
            StBranch: begin
                ALUSrcB   = SrcBImm;
                ResultSrc = ResAluResult;
                PCWrite   = condex;
            end
            default: ;
        endcase
        // Reset holds FETCH decode but must not commit PC or IR.
        PCWrite = PCWrite & rst_n;
        IRWrite = IRWrite & rst_n;
    end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench: instruction-level reference model queues per-cycle control words.
module tb_arm_mc_controller;

`ifdef ARM_CTRL_CMP_EN
    localparam bit CmpEn = 1'b1;
`else
    localparam bit CmpEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] Instr = 12'hE08;
    logic        aluZero = 1'b0, aluNeg = 1'b0;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, aluCtrl;

    arm_mc_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Instr     (Instr),
        .aluZero   (aluZero),
        .aluNeg    (aluNeg),
        .PCWrite   (PCWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .aluCtrl   (aluCtrl)
    );

    always #5 clk = ~clk;

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,RegSrc,aluCtrl}
    wire [15:0] act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                       ALUSrcB, ResultSrc, ImmSrc, RegSrc, aluCtrl};

    typedef struct {
        string       name;
        logic [15:0] v;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   m_n = 1'b0, m_z = 1'b0;   // reference flags

    task automatic check(input string name, input logic [15:0] a, input logic [15:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, act, e.v);
            end
        end
    end

    function automatic logic [15:0] common(input logic [11:0] ins);
        logic [15:0] v = '0;
        v[5:4] = ins[7:6];
        v[3]   = (ins[7:6] == 2'b01);
        v[2]   = (ins[7:6] == 2'b10);
        return v;
    endfunction

    function automatic logic [15:0] fetch_word(input logic [11:0] ins, input bit live);
        logic [15:0] v = common(ins);
        v[15] = live; v[12] = live; v[10] = 1'b1; v[9:8] = 2'b10; v[7:6] = 2'b10;
        return v;
    endfunction

    function automatic logic [15:0] decode_word(input logic [11:0] ins);
        logic [15:0] v = common(ins);
        v[10] = 1'b1; v[9:8] = 2'b10; v[7:6] = 2'b10;
        return v;
    endfunction

    function automatic bit passes(input logic [3:0] cond);
        case (cond)
            4'h0:    return m_z;
            4'h1:    return !m_z;
            4'h4:    return m_n;
            4'h5:    return !m_n;
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input string name, input logic [15:0] e, input bit z, input bit n);
        aluZero = z;
        aluNeg  = n;
        q.push_back('{name, e});
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_step(input string name, input logic [15:0] e);
        step(name, e, 1'($urandom), 1'($urandom));
    endtask

    // One complete instruction; z/n are the ALU result during the execute cycle.
    task automatic run_instr(input logic [11:0] ins, input bit z, input bit n);
        logic [15:0] v;
        logic [1:0]  op = ins[7:6];
        logic [3:0]  cmd = ins[4:1];
        bit          sup, cmp;
        logic [1:0]  alu;
        Instr = ins;
        rnd_step("fetch", fetch_word(ins, 1'b1));
        rnd_step("decode", decode_word(ins));
        if (op == 2'b01) begin
            v = common(ins); v[9:8] = 2'b01;
            rnd_step("memadr", v);
            if (ins[0]) begin
                v = common(ins); v[11] = 1'b1;
                rnd_step("memread", v);
                v = common(ins); v[7:6] = 2'b01; v[13] = passes(ins[11:8]);
                rnd_step("memwb", v);
            end else begin
                v = common(ins); v[11] = 1'b1; v[14] = passes(ins[11:8]);
                rnd_step("memwrite", v);
            end
        end else if (op == 2'b00) begin
            cmp = 1'b0;
            case (cmd)
                4'b0100: begin sup = 1'b1; alu = 2'b00; end
                4'b0010: begin sup = 1'b1; alu = 2'b01; end
                4'b0000: begin sup = 1'b1; alu = 2'b10; end
                4'b1100: begin sup = 1'b1; alu = 2'b11; end
                4'b1010: begin sup = CmpEn; cmp = CmpEn; alu = CmpEn ? 2'b01 : 2'b00; end
                default: begin sup = 1'b0; alu = 2'b00; end
            endcase
            v = common(ins); v[9:8] = ins[5] ? 2'b01 : 2'b00; v[1:0] = alu;
            if (sup && passes(ins[11:8]) && (ins[0] || cmp)) begin
                step("execute", v, z, n);
                m_z = z;
                m_n = n;
            end else begin
                step("execute", v, z, n);
            end
            if (!cmp) begin
                v = common(ins); v[13] = passes(ins[11:8]) && sup;
                rnd_step("aluwb", v);
            end
        end else if (op == 2'b10) begin
            v = common(ins); v[9:8] = 2'b01; v[7:6] = 2'b10; v[15] = passes(ins[11:8]);
            rnd_step("branch", v);
        end
    endtask

    function automatic logic [11:0] rand_instr();
        logic [3:0] conds [6] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'hE, 4'hE};
        logic [3:0] cmds  [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        logic [11:0] ins = 12'($urandom);
        if ($urandom_range(0, 7) != 0) ins[11:8] = conds[$urandom_range(0, 5)];
        if ($urandom_range(0, 4) != 0) ins[4:1] = cmds[$urandom_range(0, 4)];
        return ins;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        logic [15:0] v;
        // Reset decode for two instruction patterns, no clock edge yet.
        #2;
        check("reset_out_add", act, fetch_word(12'hE08, 1'b0));
        Instr = 12'h0A0;
        #1;
        check("reset_out_beq", act, fetch_word(12'h0A0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(12'hE08, 1'b0, 1'b0);           // ADD reg
        run_instr(12'hE25, 1'b1, 1'b0);           // SUBS imm -> Z=1
        run_instr(12'h0A0, 1'b0, 1'b0);           // BEQ taken
        run_instr(12'h1A0, 1'b0, 1'b0);           // BNE not taken
        run_instr(12'hE25, 1'b0, 1'b1);           // SUBS -> Z=0 N=1
        run_instr(12'h0A0, 1'b0, 1'b0);           // BEQ not taken
        run_instr(12'h4A0, 1'b0, 1'b0);           // BMI taken
        run_instr(12'hE59, 1'b0, 1'b0);           // LDR
        run_instr(12'hE58, 1'b0, 1'b0);           // STR
        run_instr(12'h058, 1'b0, 1'b0);           // STREQ, not executed
        run_instr(12'hE35, 1'b1, 1'b0);           // CMP (or unsupported)
        run_instr(12'h0A0, 1'b0, 1'b0);
        run_instr(12'hEC0, 1'b0, 1'b0);           // op=11 no-op

        // Reset during ALUWB: set Z first so the flag clear is observable.
        run_instr(12'hE25, 1'b1, 1'b0);
        Instr = 12'hE08;
        rnd_step("fetch", fetch_word(12'hE08, 1'b1));
        rnd_step("decode", decode_word(12'hE08));
        v = common(12'hE08);
        rnd_step("execute", v);
        v = common(12'hE08); v[13] = 1'b1;
        q.push_back('{"aluwb_pre_reset", v});
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_regwrite", {15'b0, RegWrite}, 16'h0000);
        check("midop_reset_out", act, fetch_word(12'hE08, 1'b0));
        @(posedge clk);
        #1;
        check("held_reset_out", act, fetch_word(12'hE08, 1'b0));
        m_n = 1'b0;
        m_z = 1'b0;
        rst_n = 1'b1;
        run_instr(12'h0A0, 1'b0, 1'b0);           // BEQ not taken after flag clear
        run_instr(12'h1A0, 1'b0, 1'b0);           // BNE taken

        for (int i = 0; i < 400; i++) begin
            run_instr(rand_instr(), 1'($urandom), 1'($urandom));
        end

        @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
